beep_scheduler: RTL
===================

Name: beep_scheduler

Overview:
- Sequences the buzzer tone generator: grants one of three requesters and plays that requester's fixed note pattern as timed notes separated by silent gaps.
- Sits between the event sources (error detector, gesture-match logic, power-on logic) and the tone generator.
- The tone generator consumes `note` and `note_vld` and produces the square wave.
- Runs in the 50 MHz system clock domain.

Parameters:
- NOTE_CYC, 26'd12_500_000, clock cycles each note is held (250 ms); legal range 1..2^26-1.
- GAP_CYC, 26'd2_500_000, clock cycles of silence after each note (50 ms); legal range 1..2^26-1.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- req  input  3  level requests; bit0 = error, bit1 = gesture match, bit2 = power-on chime. Each requester holds its bit high until it sees its ack.
- cancel  input  1  abort the pattern currently playing.
- ack  output  3  one-hot, one-cycle grant pulse to the granted requester.
- note  output  3  tone code to the tone generator: 0 = silence, 1..7 = DO, RE, MI, FA, SO, LA, XI.
- note_vld  output  1  high while a note (non-silence) is being played.
- busy  output  1  high while a pattern is in progress.
- done  output  1  one-cycle pulse on natural completion of a pattern.

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst_n is asynchronous, active-low. All state and outputs are registered.
- Reset values: state = IDLE; counter = 0; note index = 0; ack = 0; note = 0; note_vld = 0; busy = 0; done = 0.
- Pattern ROM: 4 slots per pattern. Code 0 in a slot terminates the pattern early.
  - P0 (error): DO, DO, DO, DO.
  - P1 (gesture): DO, MI, SO, 0.
  - P2 (chime): DO, RE, MI, FA.
- Priority is fixed: bit0 > bit1 > bit2. There is no preemption; requests are sampled only in IDLE.
- FSM states: IDLE, NOTE, GAP.
- IDLE:
  - If req != 0 at an edge: ack[winner] = 1 for that cycle; state -> NOTE; note = slot0 code; note_vld = 1; busy = 1; counter = 0; index = 0.
  - Non-granted requests stay pending and are re-arbitrated when IDLE is next entered.
- NOTE:
  - `note` is held for exactly NOTE_CYC cycles, counted starting with the ack cycle.
  - When counter == NOTE_CYC-1: state -> GAP; note = 0; note_vld = 0; counter = 0.
- GAP:
  - Lasts exactly GAP_CYC cycles. busy stays 1.
  - When counter == GAP_CYC-1, and index == 3 or the next slot code == 0: state -> IDLE; busy = 0; done = 1 for one cycle.
  - Otherwise at counter == GAP_CYC-1: index+1; state -> NOTE with the next code.
- Total busy length: N*(NOTE_CYC+GAP_CYC) cycles for an N-note pattern.
- Grant spacing: the earliest next ack is the cycle after the done cycle, i.e. one dead IDLE cycle.
- cancel in NOTE or GAP:
  - Next edge: state -> IDLE; note = 0; note_vld = 0; busy = 0.
  - done is not asserted and counter/index are cleared.
  - cancel outranks a simultaneous pattern end: done is suppressed.
- cancel in IDLE: no effect. If cancel and req are both high in IDLE, the grant proceeds.
- req changing while busy: ignored. A requester that drops req before ack loses its place.
- Reset mid-pattern: all outputs return to reset values immediately (asynchronous). No done or ack is produced.
- Counter: 26-bit unsigned; it never wraps because it is compared with ==.
- The winning requester's pattern is latched at grant; later req changes do not alter the pattern.

Test Plan:
(Bench parameters: NOTE_CYC = 4, GAP_CYC = 2. Cycle 0 = ack cycle.)
1. Reset release, req = 0 for 20 cycles -> ack = 0, note = 0, note_vld = 0, busy = 0, done = 0 throughout.
2. req = 3'b010 held until ack ->
   - ack = 3'b010 at cycle 0.
   - note = 1 for cycles 0-3, 0 for cycles 4-5, 3 for cycles 6-9, 0 for 10-11, 5 for 12-15, 0 for 16-17.
   - busy = 1 for cycles 0-17; done = 1 at cycle 18.
3. req = 3'b111 in IDLE ->
   - ack = 3'b001; the four-note DO pattern plays (busy for 24 cycles), then done.
   - Next ack = 3'b010 one cycle after done.
   - Once bit1 drops, ack = 3'b100 one cycle after the following done.
4. Chime (req = 3'b100) granted; cancel pulsed at cycle 7 (second note) -> next cycle note = 0, busy = 0; done is never asserted; a new req is granted the following cycle.
5. cancel asserted in the same cycle as the final gap cycle of pattern P1 -> done stays 0; busy falls.
6. sys_rst_n driven low mid-NOTE (asynchronously, between clock edges) -> note, note_vld and busy drop without waiting for a clock edge. After release with req still held, a fresh ack is issued and the pattern restarts from slot 0.

Source files
------------

// File: rtl/beep_scheduler.sv
// Purpose: arbitrates three buzzer requesters and plays the winner's note pattern as timed notes and gaps.
// Latency: ack, note, note_vld and busy change on the edge that samples req in IDLE; every output is registered.
// Backpressure: none; requesters hold req until ack, requests are sampled only in IDLE, and cancel aborts a pattern.
module beep_scheduler #(
  parameter logic [25:0] NOTE_CYC = 26'd12_500_000,
  parameter logic [25:0] GAP_CYC  = 26'd2_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] req,
  input  logic       cancel,
  output logic [2:0] ack,
  output logic [2:0] note,
  output logic       note_vld,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [25:0] r_cnt;
  logic [1:0]  r_idx;
  logic [1:0]  r_pat;
  logic [2:0]  r_ack;
  logic [2:0]  r_note;
  logic        r_note_vld;
  logic        r_busy;
  logic        r_done;

  logic [2:0]  w_win_oh;
  logic [1:0]  w_win_pat;
  logic [1:0]  w_next_idx;
  logic [2:0]  w_next_code;
  logic [2:0]  w_first_code;

  // Pattern ROM: code 0 in a slot ends the pattern early.
  function automatic logic [2:0] f_rom(input logic [1:0] pat, input logic [1:0] idx);
    logic [2:0] code;
    code = 3'd0;
    case (pat)
      2'd0: code = 3'd1;                       // DO DO DO DO
      2'd1: begin                              // DO MI SO, then stop
        case (idx)
          2'd0:    code = 3'd1;
          2'd1:    code = 3'd3;
          2'd2:    code = 3'd5;
          default: code = 3'd0;
        endcase
      end
      2'd2: code = {1'b0, idx} + 3'd1;         // DO RE MI FA
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // Fixed-priority winner among the pending requests: bit0 first.
  always_comb begin
    w_win_oh  = 3'b000;
    w_win_pat = 2'd0;
    if (req[0]) begin
      w_win_oh  = 3'b001;
      w_win_pat = 2'd0;
    end else if (req[1]) begin
      w_win_oh  = 3'b010;
      w_win_pat = 2'd1;
    end else if (req[2]) begin
      w_win_oh  = 3'b100;
      w_win_pat = 2'd2;
    end
  end

  // Look up the code for the grant slot and for the slot after the current one.
  always_comb begin
    w_next_idx   = r_idx + 2'd1;
    w_next_code  = f_rom(r_pat, w_next_idx);
    w_first_code = f_rom(w_win_pat, 2'd0);
  end

  // Sequencer: grant in IDLE, time each note and gap, cancel aborts without done.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 26'd0;
      r_idx      <= 2'd0;
      r_pat      <= 2'd0;
      r_ack      <= 3'b000;
      r_note     <= 3'd0;
      r_note_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ack  <= 3'b000;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // cancel has no meaning here; a simultaneous request is still granted
          if (req != 3'b000) begin
            r_ack      <= w_win_oh;
            r_pat      <= w_win_pat;
            r_state    <= S_NOTE;
            r_note     <= w_first_code;
            r_note_vld <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= 26'd0;
            r_idx      <= 2'd0;
          end
        end
        S_NOTE: begin
          if (cancel) begin
            r_state    <= S_IDLE;
            r_note     <= 3'd0;
            r_note_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= 26'd0;
            r_idx      <= 2'd0;
          end else if (r_cnt == NOTE_CYC - 26'd1) begin
            r_state    <= S_GAP;
            r_note     <= 3'd0;
            r_note_vld <= 1'b0;
            r_cnt      <= 26'd0;
          end else begin
            r_cnt <= r_cnt + 26'd1;
          end
        end
        S_GAP: begin
          // cancel wins over a pattern end landing on the same cycle
          if (cancel) begin
            r_state    <= S_IDLE;
            r_note     <= 3'd0;
            r_note_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= 26'd0;
            r_idx      <= 2'd0;
          end else if (r_cnt == GAP_CYC - 26'd1) begin
            r_cnt <= 26'd0;
            if ((r_idx == 2'd3) || (w_next_code == 3'd0)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= 2'd0;
            end else begin
              r_state    <= S_NOTE;
              r_idx      <= w_next_idx;
              r_note     <= w_next_code;
              r_note_vld <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 26'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_note     <= 3'd0;
          r_note_vld <= 1'b0;
          r_busy     <= 1'b0;
          r_cnt      <= 26'd0;
          r_idx      <= 2'd0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign note     = r_note;
  assign note_vld = r_note_vld;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
